// File: rtl/wb_dcache_flush_ctrl_if.sv
// Flush-sequencer bus: controller request/ack, tag-array port and writeback handshake.
// The master modport is the sequencer's view; slave is the surrounding cache.
interface wb_dcache_flush_ctrl_if #(
  parameter int unsigned NumSets = 256,
  parameter int unsigned NumWays = 8
) ();
  localparam int unsigned SetW = $clog2(NumSets);
  localparam int unsigned WayW = $clog2(NumWays);

  logic            flush_i;
  logic            busy_o;
  logic            flush_ack_o;
  logic            tag_req_o;
  logic            tag_we_o;
  logic            tag_gnt_i;
  logic [SetW-1:0] set_o;
  logic [WayW-1:0] way_o;
  logic            line_valid_i;
  logic            line_dirty_i;
  logic            wr_valid_o;
  logic            wr_dirty_o;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [15:0]     wb_count_o;

  modport master (
    input  flush_i, tag_gnt_i, line_valid_i, line_dirty_i, wb_ready_i,
    output busy_o, flush_ack_o, tag_req_o, tag_we_o, set_o, way_o,
           wr_valid_o, wr_dirty_o, wb_valid_o, wb_count_o
  );

  modport slave (
    output flush_i, tag_gnt_i, line_valid_i, line_dirty_i, wb_ready_i,
    input  busy_o, flush_ack_o, tag_req_o, tag_we_o, set_o, way_o,
           wr_valid_o, wr_dirty_o, wb_valid_o, wb_count_o
  );
endinterface

// File: rtl/wb_dcache_flush_ctrl.sv
// Fence-triggered dcache flush sequencer: walks every set/way, writes back dirty lines,
// then clears dirty (and optionally valid) in the tag array before acknowledging.
module wb_dcache_flush_ctrl #(
  parameter int unsigned NumSets           = 256,
  parameter int unsigned NumWays           = 8,
  parameter bit          InvalidateOnFlush = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  wb_dcache_flush_ctrl_if.master bus
);
  localparam int unsigned SetW = $clog2(NumSets);
  localparam int unsigned WayW = $clog2(NumWays);
  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RSP  = 3'd2,
    WB   = 3'd3,
    UPD  = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [SetW-1:0] set_q, set_d;
  logic [WayW-1:0] way_q, way_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            wbv_q, wbv_d;
  logic            wrv_q, wrv_d;

  logic            advance;
  logic            last_way;
  logic            last_set;

  assign last_way = (way_q == WayW'(NumWays - 1));
  assign last_set = (set_q == SetW'(NumSets - 1));

  // Next-state, index/counter update and registered output decode of the next state.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = RD;
          set_d   = '0;
          way_d   = '0;
          cnt_d   = '0;
        end
      end
      RD: begin
        if (bus.tag_gnt_i) state_d = RSP;
      end
      RSP: begin
        if (bus.line_valid_i && bus.line_dirty_i) begin
          state_d = WB;
        end else if (bus.line_valid_i && InvalidateOnFlush) begin
          state_d = UPD;
        end else begin
          advance = 1'b1;
        end
      end
      WB: begin
        if (bus.wb_ready_i) begin
          state_d = UPD;
          if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
        end
      end
      UPD: begin
        if (bus.tag_gnt_i) advance = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line walk is set-major, way-minor; the last line of the last set finishes the flush.
    if (advance) begin
      if (last_way && last_set) begin
        state_d = DONE;
      end else begin
        state_d = RD;
        if (last_way) begin
          way_d = '0;
          set_d = set_q + SetW'(1);
        end else begin
          way_d = way_q + WayW'(1);
        end
      end
    end

    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
    req_d  = (state_d == RD) || (state_d == UPD);
    we_d   = (state_d == UPD);
    wbv_d  = (state_d == WB);
    wrv_d  = (state_d == UPD) && !InvalidateOnFlush;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wbv_q   <= 1'b0;
      wrv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wbv_q   <= wbv_d;
      wrv_q   <= wrv_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.flush_ack_o = ack_q;
  assign bus.tag_req_o   = req_q;
  assign bus.tag_we_o    = we_q;
  assign bus.set_o       = set_q;
  assign bus.way_o       = way_q;
  assign bus.wr_valid_o  = wrv_q;
  assign bus.wr_dirty_o  = 1'b0;
  assign bus.wb_valid_o  = wbv_q;
  assign bus.wb_count_o  = cnt_q;

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// Bench for wb_dcache_flush_ctrl: two instances (plain flush and invalidate-on-flush),
// a line-state memory per instance, and an event/timing model derived from line contents.
module tb_wb_dcache_flush_ctrl;
  localparam int unsigned NumSets = 4;
  localparam int unsigned NumWays = 2;
  localparam int          Lines   = 8;
  localparam int          KWb     = 0;
  localparam int          KUpd    = 1;

  typedef struct packed {
    logic        busy;
    logic        ack;
    logic        req;
    logic        we;
    logic        wrv;
    logic        wrd;
    logic        wbv;
    logic [1:0]  set;
    logic        way;
    logic [15:0] cnt;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic gnt_v [2] = '{1'b1, 1'b1};
  logic rdy_v [2] = '{1'b1, 1'b1};
  logic lv_v  [2] = '{1'b0, 1'b0};
  logic ld_v  [2] = '{1'b0, 1'b0};

  // Stimulus-owned line contents and per-flush configuration.
  bit mem_v [2][Lines];
  bit mem_d [2][Lines];
  int gst_cfg [2];
  int gtarget_cfg [2];
  int wbst_cfg [2];
  int lit_ack_cfg [2];
  int lit_cnt_cfg [2];
  bit tmo = 1'b0;

  // Model state, owned by the compare process.
  int cyc = 0;
  bit mbusy [2];
  int ack_edge [2];
  int exp_line [2];
  int exp_cnt [2];
  int ev_kind [2][24];
  int ev_line [2][24];
  int ev_head [2];
  int ev_tail [2];
  bit rd_pend [2];
  int rd_line [2];
  int gst [2];
  int gtarget [2];
  int wbst [2];
  int hold_kind [2];
  int hold_line [2];
  bit post_rst [2];

  int nvec = 0;
  int nerr = 0;

  obs_t o0, o1;

  wb_dcache_flush_ctrl_if #(.NumSets(NumSets), .NumWays(NumWays)) if0 ();
  wb_dcache_flush_ctrl_if #(.NumSets(NumSets), .NumWays(NumWays)) if1 ();

  assign if0.flush_i      = flush;
  assign if0.tag_gnt_i    = gnt_v[0];
  assign if0.wb_ready_i   = rdy_v[0];
  assign if0.line_valid_i = lv_v[0];
  assign if0.line_dirty_i = ld_v[0];
  assign if1.flush_i      = flush;
  assign if1.tag_gnt_i    = gnt_v[1];
  assign if1.wb_ready_i   = rdy_v[1];
  assign if1.line_valid_i = lv_v[1];
  assign if1.line_dirty_i = ld_v[1];

  wb_dcache_flush_ctrl #(
    .NumSets(NumSets), .NumWays(NumWays), .InvalidateOnFlush(1'b0)
  ) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if0)
  );

  wb_dcache_flush_ctrl #(
    .NumSets(NumSets), .NumWays(NumWays), .InvalidateOnFlush(1'b1)
  ) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int i, input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL inst%0d %s: got %0d expected %0d (cycle %0d)", i, nm, act, exp, cyc);
    end
  endtask

  // One cycle of checking, responder and model for instance i; runs on the falling edge.
  task automatic env_step(input int i, input obs_t o);
    int ln;
    int p;
    int cost;
    bit g;
    bit r;
    bit inv;
    bit avail;
    inv = (i == 1);
    ln  = int'(o.set) * int'(NumWays) + int'(o.way);

    chk(i, "busy", int'(o.busy), int'(mbusy[i]));
    chk(i, "flush_ack", int'(o.ack), int'(mbusy[i] && (cyc == ack_edge[i])));
    chk(i, "wb_count", int'(o.cnt), exp_cnt[i]);
    chk(i, "wr_dirty", int'(o.wrd), 0);
    if (!mbusy[i]) begin
      chk(i, "idle_tag_req", int'(o.req), 0);
      chk(i, "idle_wb_valid", int'(o.wbv), 0);
    end
    if (post_rst[i]) begin
      chk(i, "rst_set", int'(o.set), 0);
      chk(i, "rst_way", int'(o.way), 0);
      chk(i, "rst_tag_we", int'(o.we), 0);
      chk(i, "rst_wr_valid", int'(o.wrv), 0);
    end
    if (hold_kind[i] == 1) begin
      chk(i, "rd_stall_req", int'(o.req && !o.we), 1);
      chk(i, "rd_stall_line", ln, hold_line[i]);
    end else if (hold_kind[i] == 2) begin
      chk(i, "wb_stall_valid", int'(o.wbv), 1);
      chk(i, "wb_stall_line", ln, hold_line[i]);
    end
    if (mbusy[i] && (cyc == ack_edge[i])) begin
      chk(i, "events_left", ev_tail[i] - ev_head[i], 0);
      chk(i, "lines_read", exp_line[i], Lines);
      if (lit_cnt_cfg[i] >= 0) chk(i, "final_wb_count", int'(o.cnt), lit_cnt_cfg[i]);
    end

    hold_kind[i] = 0;
    post_rst[i]  = 1'b0;

    g = 1'b1;
    r = 1'b1;
    if (o.req && !o.we && (ln == gtarget[i]) && (gst[i] > 0)) begin
      g = 1'b0;
      gst[i]--;
    end
    if (o.wbv && (wbst[i] > 0)) begin
      r = 1'b0;
      wbst[i]--;
    end
    gnt_v[i] = g;
    rdy_v[i] = r;
    // Junk line state outside the response cycle exposes sampling at the wrong time.
    lv_v[i] = 1'b1;
    ld_v[i] = 1'b1;
    if (rd_pend[i]) begin
      lv_v[i]    = mem_v[i][rd_line[i]];
      ld_v[i]    = mem_d[i][rd_line[i]];
      rd_pend[i] = 1'b0;
    end

    if (rst_n) begin
      if (o.req && g) begin
        if (!o.we) begin
          chk(i, "read_line", ln, exp_line[i]);
          exp_line[i]++;
          rd_pend[i] = 1'b1;
          rd_line[i] = ln;
        end else begin
          avail = (ev_tail[i] > ev_head[i]);
          chk(i, "upd_expected", int'(avail), 1);
          if (avail) begin
            chk(i, "upd_kind", KUpd, ev_kind[i][ev_head[i]]);
            chk(i, "upd_line", ln, ev_line[i][ev_head[i]]);
            chk(i, "upd_wr_valid", int'(o.wrv), int'(!inv));
            ev_head[i]++;
          end
        end
      end
      if (o.wbv && r) begin
        avail = (ev_tail[i] > ev_head[i]);
        chk(i, "wb_expected", int'(avail), 1);
        if (avail) begin
          chk(i, "wb_kind", KWb, ev_kind[i][ev_head[i]]);
          chk(i, "wb_line", ln, ev_line[i][ev_head[i]]);
          ev_head[i]++;
          exp_cnt[i]++;
        end
      end
      if (o.req && !o.we && !g) begin
        hold_kind[i] = 1;
        hold_line[i] = exp_line[i];
      end else if (o.wbv && !r && (ev_tail[i] > ev_head[i])) begin
        hold_kind[i] = 2;
        hold_line[i] = ev_line[i][ev_head[i]];
      end
    end

    if (!rst_n) begin
      mbusy[i]    = 1'b0;
      ev_head[i]  = 0;
      ev_tail[i]  = 0;
      exp_cnt[i]  = 0;
      exp_line[i] = 0;
      rd_pend[i]  = 1'b0;
      gst[i]      = 0;
      wbst[i]     = 0;
      post_rst[i] = 1'b1;
    end else if (mbusy[i] && (cyc == ack_edge[i])) begin
      mbusy[i] = 1'b0;
    end else if (!mbusy[i] && flush) begin
      p           = cyc + 1;
      cost        = 0;
      ev_head[i]  = 0;
      ev_tail[i]  = 0;
      exp_line[i] = 0;
      exp_cnt[i]  = 0;
      for (int l = 0; l < Lines; l++) begin
        cost += 2;
        if (mem_v[i][l] && mem_d[i][l]) begin
          ev_kind[i][ev_tail[i]] = KWb;  ev_line[i][ev_tail[i]] = l; ev_tail[i]++;
          ev_kind[i][ev_tail[i]] = KUpd; ev_line[i][ev_tail[i]] = l; ev_tail[i]++;
          cost += 2;
        end else if (mem_v[i][l] && inv) begin
          ev_kind[i][ev_tail[i]] = KUpd; ev_line[i][ev_tail[i]] = l; ev_tail[i]++;
          cost += 1;
        end
      end
      gst[i]     = gst_cfg[i];
      gtarget[i] = gtarget_cfg[i];
      wbst[i]    = wbst_cfg[i];
      cost += gst_cfg[i] + wbst_cfg[i];
      ack_edge[i] = p + cost;
      if (lit_ack_cfg[i] >= 0) chk(i, "model_ack_cycle", cost + 1, lit_ack_cfg[i]);
      mbusy[i] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    o0 = {if0.busy_o, if0.flush_ack_o, if0.tag_req_o, if0.tag_we_o, if0.wr_valid_o,
          if0.wr_dirty_o, if0.wb_valid_o, if0.set_o, if0.way_o, if0.wb_count_o};
    o1 = {if1.busy_o, if1.flush_ack_o, if1.tag_req_o, if1.tag_we_o, if1.wr_valid_o,
          if1.wr_dirty_o, if1.wb_valid_o, if1.set_o, if1.way_o, if1.wb_count_o};
    chk(0, "wait_timeout", int'(tmo), 0);
    env_step(0, o0);
    env_step(1, o1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input int i, input bit [7:0] v, input bit [7:0] d);
    for (int l = 0; l < Lines; l++) begin
      mem_v[i][l] = v[l];
      mem_d[i][l] = d[l];
    end
  endtask

  task automatic set_cfg(input int a0, input int a1, input int c0, input int c1);
    lit_ack_cfg[0] = a0;
    lit_ack_cfg[1] = a1;
    lit_cnt_cfg[0] = c0;
    lit_cnt_cfg[1] = c1;
    for (int i = 0; i < 2; i++) begin
      gst_cfg[i]     = 0;
      gtarget_cfg[i] = 0;
      wbst_cfg[i]    = 0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mbusy[0] || mbusy[1]) && (n < 500)) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int n;
    set_cfg(-1, -1, -1, -1);
    set_mem(0, 8'h00, 8'h00);
    set_mem(1, 8'h00, 8'h00);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // All lines invalid.
    set_cfg(17, 17, 0, 0);
    pulse_flush();
    wait_idle();

    // (set1,way0) and (set3,way1) dirty.
    set_mem(0, 8'h84, 8'h84);
    set_mem(1, 8'h84, 8'h84);
    set_cfg(21, 21, 2, 2);
    pulse_flush();
    wait_idle();

    // Every line valid, lines 0,3,4,6 dirty.
    set_mem(0, 8'hFF, 8'h59);
    set_mem(1, 8'hFF, 8'h59);
    set_cfg(25, 29, 4, 4);
    pulse_flush();
    wait_idle();

    // Grant held off 5 cycles at (set2,way1), ready held off 3 cycles in the first WB.
    set_mem(0, 8'h84, 8'h84);
    set_mem(1, 8'h84, 8'h84);
    set_cfg(29, 21, 2, 2);
    gst_cfg[0]     = 5;
    gtarget_cfg[0] = 5;
    wbst_cfg[0]    = 3;
    pulse_flush();
    wait_idle();

    // Reset while in WB aborts; a fresh flush restarts from line 0.
    set_cfg(-1, -1, -1, -1);
    pulse_flush();
    n = 0;
    while (!if0.wb_valid_o && (n < 100)) begin
      tick();
      n++;
    end
    if (n >= 100) tmo = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    set_cfg(21, 21, 2, 2);
    pulse_flush();
    wait_idle();

    // Re-request while busy is ignored.
    pulse_flush();
    repeat (5) tick();
    pulse_flush();
    wait_idle();

    // Request held high: second flush starts right after DONE with the count cleared.
    flush = 1'b1;
    n = 0;
    while (!(mbusy[0] && mbusy[1]) && (n < 20)) begin
      tick();
      n++;
    end
    n = 0;
    while ((mbusy[0] || mbusy[1]) && (n < 200)) begin
      tick();
      n++;
    end
    tick();
    flush = 1'b0;
    wait_idle();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_dcache_flush_ctrl.md
# wb_dcache_flush_ctrl

Sequencer for fence-triggered flush of the write-back data cache. On a flush request it walks every set/way, reads each line's state through the shared tag-array port, and writes back every valid dirty line. It then clears the dirty bit, or also the valid bit when invalidate-on-flush is configured, and acknowledges completion to the controller. It sits between the cache controller (fence/flush request) and the dcache tag-array arbiter and writeback unit.

## Interface
- NumSets, 256, number of cache sets; power of two, ≥2 (32 KiB / 8 ways / 16 B lines)
- NumWays, 8, associativity; power of two, ≥2
- InvalidateOnFlush, 0, 1: flushed lines also have valid cleared
- SetW = $clog2(NumSets), WayW = $clog2(NumWays) (derived)

- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- flush_i  in  1  flush request, level or pulse; sampled only in IDLE
- busy_o  out  1  flush in progress (state ≠ IDLE)
- flush_ack_o  out  1  one-cycle completion pulse
- tag_req_o  out  1  request to tag-array arbiter
- tag_we_o  out  1  0 = state read, 1 = state write
- tag_gnt_i  in  1  arbiter grant; the access completes in the grant cycle
- set_o  out  SetW  current set index
- way_o  out  WayW  current way index
- line_valid_i  in  1  valid bit of the read line; valid the cycle after the read grant
- line_dirty_i  in  1  dirty bit of the read line; same timing as line_valid_i
- wr_valid_o  out  1  write-state value: valid bit to store
- wr_dirty_o  out  1  write-state value: dirty bit to store (always 0)
- wb_valid_o  out  1  writeback request for set_o/way_o
- wb_ready_i  in  1  writeback unit accepts the request
- wb_count_o  out  16  lines written back in the current/last flush; saturates at 0xFFFF

## Operation
- FSM states: IDLE, RD, RSP, WB, UPD, DONE.
- IDLE: all request outputs 0.
  - flush_i=1 → RD. Set and way counters go to 0; wb_count_o goes to 0.
- RD: tag_req_o=1, tag_we_o=0.
  - tag_gnt_i=1 → RSP.
  - Otherwise hold, with request and indices stable.
- RSP: sample line_valid_i and line_dirty_i.
  - valid & dirty → WB.
  - valid & !dirty & InvalidateOnFlush → UPD.
  - Otherwise → advance.
- WB: wb_valid_o=1; set_o/way_o held.
  - wb_ready_i=1 → UPD, and wb_count_o increments (saturating).
  - wb_valid_o must not drop before acceptance.
- UPD: tag_req_o=1, tag_we_o=1, wr_dirty_o=0, wr_valid_o=!InvalidateOnFlush.
  - tag_gnt_i=1 → advance.
- Advance (taken as part of the RSP/UPD exit):
  - If way = NumWays-1 and set = NumSets-1 → DONE.
  - Else if way = NumWays-1 → way=0, set+1, → RD.
  - Else → way+1, → RD.
- DONE: flush_ack_o=1 for exactly one cycle → IDLE.
- flush_i while busy is ignored; no queuing. A flush_i held high through DONE starts a new flush from IDLE on the following cycle.
- Invalid lines are never written back or updated.
- Line order is fixed: set-major, way-minor, ascending.

## Timing
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE; set, way and wb_count_o = 0.
  - busy_o, flush_ack_o, tag_req_o, tag_we_o, wb_valid_o, wr_valid_o, wr_dirty_o = 0.
- Reset mid-flush aborts immediately; there is no ack and no partial-state completion.
- All outputs are registered state decodes; there are no combinational paths from inputs to outputs.
- With grants and ready always high, per-line cost is:
  - clean line: 2 cycles (RD, RSP)
  - dirty line: 4 cycles (RD, RSP, WB, UPD)
  - clean valid line with InvalidateOnFlush: 3 cycles
- Completion timing, with flush_i sampled in cycle 0 and L = NumSets·NumWays:
  - all lines clean/invalid: flush_ack_o high in cycle 2L+1
  - each dirty line adds 2 cycles
- Stalls on tag_gnt_i or wb_ready_i extend the current state 1:1 and leave the indices unchanged.

## Test plan
- NumSets=4, NumWays=2, all lines invalid, grants/ready tied 1. Pulse flush_i in cycle 0 → flush_ack_o in cycle 17; no wb_valid_o; wb_count_o=0; busy_o high in cycles 1–17.
- Same configuration, lines (set1,way0) and (set3,way1) valid+dirty → exactly two wb_valid_o handshakes, in that order, each followed by a UPD write with wr_dirty_o=0, wr_valid_o=1; wb_count_o=2; ack in cycle 21.
- InvalidateOnFlush=1, all 8 lines valid with 4 dirty → 4 writebacks and 8 UPD writes with wr_valid_o=0; ack in cycle 29.
- tag_gnt_i low for 5 cycles during the RD of (set2,way1), and wb_ready_i low for 3 cycles in WB → set_o/way_o/wb_valid_o stable throughout; ack delayed by exactly 8 cycles.
- rst_ni=0 for one cycle while in WB → next cycle state IDLE, all outputs 0, no ack. A new flush_i restarts from set0/way0.
- flush_i re-asserted during a busy flush → ignored (single ack). flush_i held high → a second flush starts right after DONE, and wb_count_o is cleared at its start.
